// File: rtl/nibble_add_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_sched_if
// Brief    : Request/result handshake bundle for the nibble adder scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_add_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    // Requesters and result consumer side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  res_valid, res_sum, res_cout, res_id,
        output res_ready
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output res_valid, res_sum, res_cout, res_id,
        input  res_ready
    );
endinterface
`default_nettype wire

// File: rtl/nibble_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_sched
// Brief    : Round-robin scheduler sharing one 4-bit adder slice over WIDTH-bit
//            operands, one nibble per clock, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_add_sched #(
    parameter int WIDTH = 16
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    nibble_add_sched_if.slave bus,
    output logic              busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_valid;
    logic             r_id;
    logic             r_ptr;

    logic             w_idle;
    logic             w_gnt1;
    logic             w_accept;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_slice_sum;
    logic             w_ripple;
    logic [CNT_W+1:0] w_shift;
    logic [WIDTH-1:0] w_sum_ins;

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign w_idle         = (r_state == S_IDLE);
    assign w_gnt1         = bus.req1_valid & (~bus.req0_valid | r_ptr);
    assign w_accept       = w_idle & (bus.req0_valid | bus.req1_valid);
    assign bus.req0_ready = w_idle & bus.req0_valid & ~w_gnt1;
    assign bus.req1_ready = w_idle & w_gnt1;

    assign w_shift = {r_cnt, 2'b00};
    assign w_nib_a = 4'(r_a >> w_shift);
    assign w_nib_b = 4'(r_b >> w_shift);

    // Shared slice: four chained full-adder stages.
    always_comb begin
        w_slice_sum = 4'd0;
        w_ripple    = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_slice_sum[i] = w_nib_a[i] ^ w_nib_b[i] ^ w_ripple;
            w_ripple       = (w_nib_a[i] & w_nib_b[i]) |
                             (w_ripple & (w_nib_a[i] ^ w_nib_b[i]));
        end
    end

    assign w_sum_ins = (r_sum & ~(WIDTH'(4'hF) << w_shift)) |
                       (WIDTH'(w_slice_sum) << w_shift);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)        w_state_next = S_ADD;
            S_ADD:   if (r_cnt == C_LAST) w_state_next = S_HOLD;
            S_HOLD:  if (bus.res_ready)   w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
            r_id    <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_gnt1 ? bus.req1_a   : bus.req0_a;
                        r_b     <= w_gnt1 ? bus.req1_b   : bus.req0_b;
                        r_carry <= w_gnt1 ? bus.req1_cin : bus.req0_cin;
                        r_id    <= w_gnt1;
                        r_cnt   <= '0;
                    end
                end
                S_ADD: begin
                    r_sum   <= w_sum_ins;
                    r_carry <= w_ripple;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_cout  <= w_ripple;
                        r_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Last served requester drops to lowest priority.
                    if (bus.res_ready) begin
                        r_valid <= 1'b0;
                        r_ptr   <= ~r_id;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_valid = r_valid;
    assign bus.res_sum   = r_sum;
    assign bus.res_cout  = r_cout;
    assign bus.res_id    = r_id;
    assign busy          = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_nibble_add_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nibble_add_sched
// Brief    : Self-checking bench: directed table, corner sequences, random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_add_sched;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk = 1'b0;
    logic resetn;
    logic busy;

    always #5 clk = ~clk;

    nibble_add_sched_if #(.WIDTH(W)) bus();

    nibble_add_sched #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave),
        .busy   (busy)
    );

    typedef struct {
        logic         rst;
        logic         v0;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic         c0;
        logic         v1;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic         c1;
        int           stall;
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_ptr = 1'b0;   // 1: requester 1 favoured on a tie

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_ptr  = 1'b0;
    endtask

    task automatic txn(input vec_t v);
        int lat;
        @(negedge clk);
        bus.req0_valid = v.v0; bus.req0_a = v.a0; bus.req0_b = v.b0; bus.req0_cin = v.c0;
        bus.req1_valid = v.v1; bus.req1_a = v.a1; bus.req1_b = v.b1; bus.req1_cin = v.c1;
        bus.res_ready  = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("grant0", bus.req0_ready, v.v0 && !v.id);
        chk("grant1", bus.req1_ready, v.v1 && v.id);
        @(posedge clk); #1;
        lat = 0;
        for (int i = 1; i <= NIB + 3 && lat == 0; i++) begin
            chk("add_busy", busy, 1);
            chk("add_ready", {bus.req0_ready, bus.req1_ready}, 0);
            chk("add_valid", bus.res_valid, 0);
            @(posedge clk); #1;
            if (bus.res_valid) lat = i;
        end
        chk("latency", lat, NIB);
        for (int s = 0; s < v.stall; s++) begin
            chk("stall_valid", bus.res_valid, 1);
            chk("stall_sum", bus.res_sum, v.sum);
            chk("stall_cout", bus.res_cout, v.cout);
            chk("stall_id", bus.res_id, v.id);
            chk("stall_busy", busy, 1);
            chk("stall_ready", {bus.req0_ready, bus.req1_ready}, 0);
            @(posedge clk); #1;
        end
        chk("res_valid", bus.res_valid, 1);
        chk("res_sum", bus.res_sum, v.sum);
        chk("res_cout", bus.res_cout, v.cout);
        chk("res_id", bus.res_id, v.id);
        bus.res_ready = 1'b1;
        #1;
        chk("hs_ready", {bus.req0_ready, bus.req1_ready}, 0);
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("post_valid", bus.res_valid, 0);
        chk("post_busy", busy, 0);
        m_ptr = !v.id;
        chk("next_ready0", bus.req0_ready, v.v0 && !(v.v1 && m_ptr));
        chk("next_ready1", bus.req1_ready, v.v1 && (!v.v0 || m_ptr));
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        vec_t         r;
        logic [W:0]   t;
        logic         g;

        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0;
        bus.res_ready  = 0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_sum", bus.res_sum, 0);
        chk("rst_cout", bus.res_cout, 0);
        chk("rst_id", bus.res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
        @(negedge clk);
        resetn = 1'b1;

        //            rst v0 a0        b0        c0 v1 a1        b1        c1 st sum       co id
        vecs[0] = '{1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1, 16'hFFFF, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b0, 0, 16'h0002, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b0, 0, 16'h0004, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b0, 0, 16'h0002, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b0, 5, 16'h0004, 1'b0, 1'b1};

        for (int k = 0; k < 8; k++) begin
            if (vecs[k].rst) do_reset();
            txn(vecs[k]);
        end

        // Valid raised and dropped between clock edges: nothing captured.
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_a = 16'h0F0F; bus.req1_b = 16'h0101;
        #1;
        chk("drop_ready", bus.req1_ready, 1);
        #2;
        bus.req1_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("drop_busy", busy, 0);
            chk("drop_valid", bus.res_valid, 0);
        end

        // Reset in the middle of an addition.
        r = '{1'b0, 1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 16'h0406, 1'b0, 1'b0};
        txn(r);
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_a = 16'h1111; bus.req1_b = 16'h2222; bus.req1_cin = 1'b0;
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        chk("mid_busy", busy, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", bus.res_valid, 0);
        chk("mid_rst_sum", bus.res_sum, 0);
        chk("mid_rst_id", bus.res_id, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        resetn = 1'b1;
        m_ptr  = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("aborted_valid", bus.res_valid, 0);
            chk("aborted_busy", busy, 0);
        end
        r = '{1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h7000, 16'h9000, 1'b1, 0, 16'h3333, 1'b0, 1'b0};
        txn(r);

        // Random traffic against an arithmetic/round-robin reference.
        for (int k = 0; k < 40; k++) begin
            r.rst = 1'b0;
            r.v0  = 1'($urandom_range(0, 1));
            r.v1  = 1'($urandom_range(0, 1));
            if (!r.v0 && !r.v1) r.v0 = 1'b1;
            r.a0 = W'($urandom); r.b0 = W'($urandom); r.c0 = 1'($urandom_range(0, 1));
            r.a1 = W'($urandom); r.b1 = W'($urandom); r.c1 = 1'($urandom_range(0, 1));
            if (k % 8 == 0) begin r.a0 = '1; r.b0 = '1; end
            r.stall = $urandom_range(0, 2);
            g = (r.v0 && r.v1) ? m_ptr : r.v1;
            if (g) t = {1'b0, r.a1} + {1'b0, r.b1} + (W+1)'(r.c1);
            else   t = {1'b0, r.a0} + {1'b0, r.b0} + (W+1)'(r.c0);
            r.sum  = t[W-1:0];
            r.cout = t[W];
            r.id   = g;
            txn(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
